multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/multicycle_control_if.sv | 40 ++++
 rtl/mc_output_decoder.sv | 83 ++++++++
 rtl/multicycle_control.sv | 85 ++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS control FSM
//
// Purpose: state encodings, opcode constants, datapath select codes and the
//          packed control word passed from the output decoder to the top.
// Ports:   none (package).

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath signal bundle
//
// Purpose: groups the instruction/memory inputs and all datapath controls.
// Ports:   master = controller (reads opcode/mem_ready, drives controls),
//          slave  = datapath side (drives opcode/mem_ready, reads controls).

interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemToReg;
  logic       IRWrite;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, state,
           instr_done, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource, state,
           instr_done, illegal
  );
endinterface

// File: rtl/mc_output_decoder.sv
// rtl/mc_output_decoder.sv - Moore output decode for the multicycle control FSM
//
// Purpose: maps the current state (plus mem_ready in the memory states) to
//          the datapath control word; all zero while reset is high.
// Ports:   state     in  current FSM state
//          mem_ready in  memory handshake
//          reset     in  forces every control to 0
//          ctrl      out packed control word

module mc_output_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   reset,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          // IR and PC only capture when the fetch read actually completes
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_IMM_SHL2;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_READ: begin
          ctrl.mem_read = 1'b1;
          ctrl.ior_d    = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl.mem_write  = 1'b1;
          ctrl.ior_d      = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        S_R_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          ctrl.reg_dst    = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_REG;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.instr_done    = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control unit (Moore FSM)
//
// Purpose: state register and next-state logic for lw/sw/R-type/beq/j;
//          output decode lives in mc_output_decoder.
// Ports:   clk   in  rising-edge clock
//          reset in  synchronous active-high reset
//          bus   master side of multicycle_control_if (opcode, mem_ready in;
//                datapath controls, state, instr_done, illegal out)

module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   decode_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  mc_output_decoder u_dec (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  // An unsupported opcode retires in DECODE, so it alone ends the instruction
  // there; this is the only output that looks at opcode.
  assign decode_illegal = !reset && (state_q == S_DECODE) && !is_supported(bus.opcode);

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.ior_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemToReg    = ctrl.mem_to_reg;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.instr_done  = ctrl.instr_done | decode_illegal;
  assign bus.illegal     = decode_illegal;
  // Reported state reads FETCH during reset even before the register clears.
  assign bus.state       = reset ? S_FETCH : state_q;

endmodule
